hazard_ctrl: RTL and testbench

Pipeline sequencing controller for the five-stage semiMIPS core. It drives the write-enable and synchronous flush pins of PC, IF/ID, ID/EX and EX/MEM. It inserts load-use bubbles and resolves branches and jumps in MEM by squashing younger instructions and redirecting the PC. It also drains the pipeline when the `fin` instruction is decoded and halts once `fin` reaches WB.

---
 rtl/hazard_ctrl.sv | 163 ++++++++++++++++
 tb/tb_hazard_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl
// Purpose  : semiMIPS pipeline sequencing. Handles load-use bubbles, MEM-stage
//            branch/jump squash and redirect, and fin drain/halt. The optional
//            statistics counters are enabled by defining HAZARD_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
    parameter int CWIDTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              idexmemrd,
    input  logic [4:0]        idexrt,
    input  logic [4:0]        ifidrs,
    input  logic [4:0]        ifidrt,
    input  logic              ifidusert,
    input  logic              ifidfin,
    input  logic              exmembbeq,
    input  logic              exmembbne,
    input  logic              exmembblez,
    input  logic              exmembbgtz,
    input  logic              exmemjump,
    input  logic              exmemzero,
    input  logic              exmemnegative,
    input  logic              finwb,
    output logic              pcwrite,
    output logic              ifidwrite,
    output logic              ifidflush,
    output logic              idexflush,
    output logic              exmemflush,
    output logic              pcsel,
    output logic              halted,
    output logic [CWIDTH-1:0] stallcnt,
    output logic [CWIDTH-1:0] flushcnt
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    state_t state;
    state_t state_next;
    logic   taken;
    logic   loaduse;

    assign taken = (exmembbeq  &  exmemzero)
                 | (exmembbne  & ~exmemzero)
                 | (exmembblez & (exmemzero | exmemnegative))
                 | (exmembbgtz & ~exmemzero & ~exmemnegative)
                 | exmemjump;

    // Register $0 is never a real dependency.
    assign loaduse = idexmemrd && (idexrt != 5'd0)
                   && ((idexrt == ifidrs) || (ifidusert && (idexrt == ifidrt)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        pcwrite    = 1'b1;
        ifidwrite  = 1'b1;
        ifidflush  = 1'b0;
        idexflush  = 1'b0;
        exmemflush = 1'b0;
        pcsel      = 1'b0;
        halted     = 1'b0;
        if (!rst) begin
            case (state)
                ST_RUN: begin
                    if (taken) begin
                        ifidflush  = 1'b1;
                        idexflush  = 1'b1;
                        exmemflush = 1'b1;
                        pcsel      = 1'b1;
                        state_next = ST_RUN;
                    end else begin
                        if (loaduse) begin
                            pcwrite   = 1'b0;
                            ifidwrite = 1'b0;
                            idexflush = 1'b1;
                        end else if (ifidfin) begin
                            pcwrite    = 1'b0;
                            ifidflush  = 1'b1;
                            state_next = ST_DRAIN;
                        end
                        // A fin at WB without a drain is malformed; stop anyway.
                        if (finwb) begin
                            state_next = ST_HALT;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (taken) begin
                        // The squashed fin was younger than the branch.
                        ifidflush  = 1'b1;
                        idexflush  = 1'b1;
                        exmemflush = 1'b1;
                        pcsel      = 1'b1;
                        state_next = ST_RUN;
                    end else begin
                        pcwrite   = 1'b0;
                        ifidflush = 1'b1;
                        if (finwb) begin
                            state_next = ST_HALT;
                        end
                    end
                end
                ST_HALT: begin
                    pcwrite   = 1'b0;
                    ifidwrite = 1'b0;
                    halted    = 1'b1;
                end
                default: begin
                    state_next = ST_RUN;
                end
            endcase
        end
    end

`ifdef HAZARD_STATS_EN
    localparam logic [CWIDTH-1:0] C_ONE = {{(CWIDTH-1){1'b0}}, 1'b1};

    logic              stall_evt;
    logic              flush_evt;
    logic [CWIDTH-1:0] stall_q;
    logic [CWIDTH-1:0] flush_q;

    assign stall_evt = (state == ST_RUN) && !taken && loaduse;
    assign flush_evt = ((state == ST_RUN) || (state == ST_DRAIN)) && taken;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (stall_evt && (stall_q != '1)) begin
                stall_q <= stall_q + C_ONE;
            end
            if (flush_evt && (flush_q != '1)) begin
                flush_q <= flush_q + C_ONE;
            end
        end
    end

    assign stallcnt = stall_q;
    assign flushcnt = flush_q;
`else
    assign stallcnt = '0;
    assign flushcnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// Testbench for hazard_ctrl: directed and random stimulus against a
// behavioural model, checked through an expected-response queue.
module tb_hazard_ctrl;

    localparam int CW = 16;

    logic clk = 1'b0;
    logic rst;
    logic idexmemrd, ifidusert, ifidfin, finwb;
    logic [4:0] idexrt, ifidrs, ifidrt;
    logic bbeq, bbne, bblez, bbgtz, jump, zero, neg;
    logic pcwrite, ifidwrite, ifidflush, idexflush, exmemflush, pcsel, halted;
    logic [CW-1:0] stallcnt, flushcnt;

    always #5 clk = ~clk;

    hazard_ctrl #(.CWIDTH(CW)) dut (
        .clk(clk), .rst(rst),
        .idexmemrd(idexmemrd), .idexrt(idexrt), .ifidrs(ifidrs), .ifidrt(ifidrt),
        .ifidusert(ifidusert), .ifidfin(ifidfin),
        .exmembbeq(bbeq), .exmembbne(bbne), .exmembblez(bblez), .exmembbgtz(bbgtz),
        .exmemjump(jump), .exmemzero(zero), .exmemnegative(neg), .finwb(finwb),
        .pcwrite(pcwrite), .ifidwrite(ifidwrite), .ifidflush(ifidflush),
        .idexflush(idexflush), .exmemflush(exmemflush), .pcsel(pcsel),
        .halted(halted), .stallcnt(stallcnt), .flushcnt(flushcnt)
    );

    typedef struct {
        logic rst, memrd, usert, fin, finwb;
        logic [4:0] rtx, rs, rt;
        logic beq, bne, blez, bgtz, jump, zero, neg;
    } stim_t;

    typedef struct {
        logic pcwrite, ifidwrite, ifidflush, idexflush, exmemflush, pcsel, halted;
        int   stall, flush;
    } resp_t;

    resp_t exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    // Model: mode 0 = running, 1 = draining after fin, 2 = halted.
    int m_mode  = 0;
    int m_stall = 0;
    int m_flush = 0;
    localparam int MAXC = (1 << CW) - 1;

    task automatic model_step(input stim_t s, output resp_t e);
        bit tk, lu;
        tk = (s.beq && s.zero) || (s.bne && !s.zero) || (s.blez && (s.zero || s.neg))
           || (s.bgtz && !s.zero && !s.neg) || s.jump;
        lu = s.memrd && (s.rtx != 0) && ((s.rtx == s.rs) || (s.usert && (s.rtx == s.rt)));
        e = '{pcwrite:1, ifidwrite:1, ifidflush:0, idexflush:0, exmemflush:0,
              pcsel:0, halted:0, stall:0, flush:0};
`ifdef HAZARD_STATS_EN
        e.stall = m_stall;
        e.flush = m_flush;
`endif
        if (s.rst) begin
            m_mode = 0; m_stall = 0; m_flush = 0;
        end else if (m_mode == 2) begin
            e.pcwrite = 0; e.ifidwrite = 0; e.halted = 1;
        end else if (tk) begin
            e.ifidflush = 1; e.idexflush = 1; e.exmemflush = 1; e.pcsel = 1;
            m_mode = 0;
            if (m_flush < MAXC) m_flush++;
        end else if (m_mode == 1) begin
            e.pcwrite = 0; e.ifidflush = 1;
            if (s.finwb) m_mode = 2;
        end else begin
            if (lu) begin
                e.pcwrite = 0; e.ifidwrite = 0; e.idexflush = 1;
                if (m_stall < MAXC) m_stall++;
            end else if (s.fin) begin
                e.pcwrite = 0; e.ifidflush = 1;
                m_mode = 1;
            end
            if (s.finwb) m_mode = 2;
        end
    endtask

    task automatic apply(input stim_t s);
        resp_t e;
        @(posedge clk);
        #1;
        rst = s.rst; idexmemrd = s.memrd; idexrt = s.rtx; ifidrs = s.rs; ifidrt = s.rt;
        ifidusert = s.usert; ifidfin = s.fin; finwb = s.finwb;
        bbeq = s.beq; bbne = s.bne; bblez = s.blez; bbgtz = s.bgtz; jump = s.jump;
        zero = s.zero; neg = s.neg;
        model_step(s, e);
        exp_q.push_back(e);
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '{rst:0, memrd:0, usert:0, fin:0, finwb:0, rtx:0, rs:0, rt:0,
              beq:0, bne:0, blez:0, bgtz:0, jump:0, zero:0, neg:0};
        return s;
    endfunction

    function automatic stim_t rnd(input bit allow_rst);
        stim_t s;
        s = idle();
        s.rst   = allow_rst && ((m_mode == 2) ? ($urandom_range(0, 7) == 0)
                                              : ($urandom_range(0, 199) == 0));
        s.memrd = $urandom_range(0, 1) == 1;
        s.usert = $urandom_range(0, 1) == 1;
        s.rtx   = 5'($urandom_range(0, 3));
        s.rs    = 5'($urandom_range(0, 3));
        s.rt    = 5'($urandom_range(0, 3));
        s.fin   = $urandom_range(0, 15) == 0;
        s.finwb = (m_mode == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 99) == 0);
        s.beq   = $urandom_range(0, 9) == 0;
        s.bne   = $urandom_range(0, 9) == 0;
        s.blez  = $urandom_range(0, 9) == 0;
        s.bgtz  = $urandom_range(0, 9) == 0;
        s.jump  = $urandom_range(0, 19) == 0;
        s.zero  = $urandom_range(0, 1) == 1;
        s.neg   = $urandom_range(0, 1) == 1;
        return s;
    endfunction

    task automatic check(input string name, input int act, input int want);
        n_checks++;
        if (act != want) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, want);
        end
    endtask

    // Monitor: outputs are combinational, so sample mid-cycle.
    initial begin
        resp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("pcwrite",    int'(pcwrite),    int'(e.pcwrite));
                check("ifidwrite",  int'(ifidwrite),  int'(e.ifidwrite));
                check("ifidflush",  int'(ifidflush),  int'(e.ifidflush));
                check("idexflush",  int'(idexflush),  int'(e.idexflush));
                check("exmemflush", int'(exmemflush), int'(e.exmemflush));
                check("pcsel",      int'(pcsel),      int'(e.pcsel));
                check("halted",     int'(halted),     int'(e.halted));
                check("stallcnt",   int'(stallcnt),   e.stall);
                check("flushcnt",   int'(flushcnt),   e.flush);
            end
        end
    end

    initial begin
        stim_t s;
        rst = 1'b1; idexmemrd = 0; idexrt = 0; ifidrs = 0; ifidrt = 0; ifidusert = 0;
        ifidfin = 0; finwb = 0; bbeq = 0; bbne = 0; bblez = 0; bbgtz = 0; jump = 0;
        zero = 0; neg = 0;

        s = idle(); s.rst = 1; apply(s); apply(s);
        apply(idle());

        // Load-use on Rs, then with $0 destination.
        s = idle(); s.memrd = 1; s.rtx = 2; s.rs = 2; apply(s);
        apply(idle());
        s = idle(); s.memrd = 1; s.rtx = 0; s.rs = 0; apply(s);
        s = idle(); s.memrd = 1; s.rtx = 3; s.rt = 3; s.usert = 1; apply(s);
        s.usert = 0; apply(s);

        // Branch conditions.
        s = idle(); s.beq = 1; s.zero = 1; apply(s);
        s = idle(); s.bne = 1; s.zero = 1; apply(s);
        s = idle(); s.bgtz = 1; s.neg = 1; apply(s);
        s = idle(); s.blez = 1; s.neg = 1; apply(s);

        // Jump together with load-use.
        s = idle(); s.jump = 1; s.memrd = 1; s.rtx = 2; s.rs = 2; apply(s);

        // fin drain then halt, followed by random inputs while halted.
        s = idle(); s.fin = 1; apply(s);
        apply(idle()); apply(idle());
        s = idle(); s.finwb = 1; apply(s);
        for (int i = 0; i < 10; i++) apply(rnd(1'b0));

        // Jump cancels a drain.
        s = idle(); s.rst = 1; apply(s);
        s = idle(); s.fin = 1; apply(s);
        apply(idle());
        s = idle(); s.jump = 1; apply(s);
        apply(idle());

        // Reset while halted with counters non-zero.
        s = idle(); s.memrd = 1; s.rtx = 1; s.rs = 1; apply(s);
        s = idle(); s.beq = 1; s.zero = 1; apply(s);
        s = idle(); s.fin = 1; apply(s);
        s = idle(); s.finwb = 1; apply(s);
        apply(idle());
        s = idle(); s.rst = 1; apply(s);
        apply(idle());

        // Malformed finwb while running.
        s = idle(); s.finwb = 1; apply(s);
        apply(idle());
        s = idle(); s.rst = 1; apply(s);

        for (int i = 0; i < 3000; i++) apply(rnd(1'b1));

        @(posedge clk);
        @(posedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
